// File: rtl/fetch_buffer.sv
// fetch_buffer: instruction fetch stage with a small prefetch queue feeding decode
module fetch_buffer #(
    parameter int unsigned DEPTH     = 4,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [31:0]                  pc_branch,
    input  logic                         pc_source,
    output logic [31:0]                  imem_addr,
    input  logic [31:0]                  imem_rdata,
    input  logic                         id_ready,
    output logic                         out_valid,
    output logic [31:0]                  pc_next_out,
    output logic [31:0]                  instr_out,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [31:0]   pc_q, pc_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [63:0]   mem_q [DEPTH];
    logic [63:0]   head;
    logic [31:0]   pc_plus4;
    logic          push;
    logic          pop;

    // Head presentation and handshake; a redirect hides the head so decode never takes a wrong-path entry
    always_comb begin
        pc_plus4    = pc_q + 32'd4;
        head        = mem_q[rd_ptr_q];
        out_valid   = (count_q != '0) && !pc_source;
        pop         = out_valid && id_ready;
        push        = !pc_source && ((count_q < CW'(DEPTH)) || pop);
        instr_out   = out_valid ? head[31:0] : NOP_INSTR;
        pc_next_out = out_valid ? head[63:32] : 32'h0;
        imem_addr   = pc_q;
        count       = count_q;
    end

    // Next state: redirect flushes the queue and loads the word-aligned target, otherwise push/pop bookkeeping
    always_comb begin
        pc_d     = pc_source ? (pc_branch & 32'hFFFF_FFFC) : (push ? pc_plus4 : pc_q);
        wr_ptr_d = pc_source ? '0 : (push ? wr_ptr_q + AW'(1) : wr_ptr_q);
        rd_ptr_d = pc_source ? '0 : (pop ? rd_ptr_q + AW'(1) : rd_ptr_q);
        count_d  = pc_source ? '0 : count_q + CW'(push) - CW'(pop);
    end

    // Control state with asynchronous reset back to the reset PC and an empty queue
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= RESET_PC;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Queue storage needs no reset: entries are only visible through count
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {pc_plus4, imem_rdata};
    end

endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed checks of fetch_buffer with a pattern-based instruction memory
module tb_fetch_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] pc_branch;
    logic        pc_source;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        id_ready;
    logic        out_valid;
    logic [31:0] pc_next_out;
    logic [31:0] instr_out;
    logic [2:0]  count;
    int          total = 0;
    int          passed = 0;

    fetch_buffer #(.DEPTH(4), .RESET_PC(32'h0), .NOP_INSTR(32'h0)) dut (
        .clk(clk), .reset(reset), .pc_branch(pc_branch), .pc_source(pc_source),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata), .id_ready(id_ready),
        .out_valid(out_valid), .pc_next_out(pc_next_out), .instr_out(instr_out),
        .count(count)
    );

    always #5 clk = ~clk;

    assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else passed++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; pc_source = 1'b0; pc_branch = 32'h0; id_ready = 1'b0;
        step();
        check("rst_valid", out_valid, 0);
        check("rst_instr", instr_out, 0);
        check("rst_pcnext", pc_next_out, 0);
        check("rst_addr", imem_addr, 0);
        check("rst_count", count, 0);
        reset = 1'b0; id_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stream_instr", instr_out, 32'hA5A5_0000 + 4 * i);
            check("stream_pcnext", pc_next_out, 4 * i + 4);
            check("stream_count", count, 1);
        end
        id_ready = 1'b0;
        step();
        step();
        check("pre_reset_count", count, 3);
        reset = 1'b1;
        #1;
        check("async_valid", out_valid, 0);
        check("async_count", count, 0);
        check("async_addr", imem_addr, 0);
        check("async_instr", instr_out, 0);
        step();
        reset = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            check("fill_count", count, (k < 4) ? k : 4);
        end
        check("full_addr", imem_addr, 32'h10);
        check("restart_instr", instr_out, 32'hA5A5_0000);
        id_ready = 1'b1;
        #1;
        check("full_pcnext", pc_next_out, 4);
        step();
        check("pushpop_count", count, 4);
        check("pushpop_addr", imem_addr, 32'h14);
        for (int i = 0; i < 5; i++) begin
            check("drain_instr", instr_out, 32'hA5A5_0004 + 4 * i);
            check("drain_pcnext", pc_next_out, 4 * i + 8);
            step();
        end
        id_ready = 1'b0;
        pc_source = 1'b1; pc_branch = 32'h43;
        #1;
        check("redir_valid", out_valid, 0);
        check("redir_instr", instr_out, 0);
        check("redir_pcnext", pc_next_out, 0);
        step();
        pc_source = 1'b0;
        check("redir_count", count, 0);
        check("redir_misalign_addr", imem_addr, 32'h40);
        check("redir_empty_valid", out_valid, 0);
        step();
        check("target_valid", out_valid, 1);
        check("target_pcnext", pc_next_out, 32'h44);
        check("target_instr", instr_out, 32'hA5A5_0040);
        step();
        step();
        check("three_count", count, 3);
        pc_source = 1'b1; pc_branch = 32'h80; id_ready = 1'b1;
        #1;
        check("redir2_valid", out_valid, 0);
        step();
        pc_source = 1'b0;
        check("redir2_count", count, 0);
        check("redir2_addr", imem_addr, 32'h80);
        step();
        check("target2_valid", out_valid, 1);
        check("target2_pcnext", pc_next_out, 32'h84);
        check("target2_instr", instr_out, 32'hA5A5_0080);
        pc_source = 1'b1; pc_branch = 32'hFFFF_FFFC;
        step();
        pc_source = 1'b0;
        check("wrap_addr", imem_addr, 32'hFFFF_FFFC);
        step();
        check("wrap_pcnext", pc_next_out, 0);
        check("wrap_instr", instr_out, 32'h5A5A_FFFC);
        check("wrap_next_addr", imem_addr, 0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fetch_buffer.md
Name: fetch_buffer

Overview:
- Instruction fetch stage with a small prefetch queue. It sits directly upstream of instruction decode and replaces the direct fetch-to-decode pipeline-register path.
- Owns the PC and drives the instruction-memory address. Enqueues each fetched {pc+4, instruction} pair and presents the queue head to decode through a valid/ready handshake.
- A taken branch resolved in the memory stage flushes the queue and redirects the PC.

Parameters:
DEPTH, 4, queue entries; power of two, >= 2
RESET_PC, 32'h0000_0000, PC value loaded on reset
NOP_INSTR, 32'h0000_0000, instruction value driven when the queue is empty

Ports:
clk  input  1  clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
pc_branch  input  32  branch target from the memory stage
pc_source  input  1  redirect request: 1 = branch taken, flush and load pc_branch
imem_addr  output  32  instruction-memory byte address; equals current PC
imem_rdata  input  32  instruction word at imem_addr; combinational read, same cycle
id_ready  input  1  decode accepts the head entry this cycle
out_valid  output  1  head entry valid
pc_next_out  output  32  pc+4 of the head instruction
instr_out  output  32  head instruction
count  output  $clog2(DEPTH+1)  occupied entries (debug/verification)

Behaviour:
- Reset (asynchronous, no clock needed):
  - pc = RESET_PC; rd_ptr = wr_ptr = 0; count = 0.
  - Outputs immediately: out_valid=0, instr_out=NOP_INSTR, pc_next_out=0, imem_addr=RESET_PC.
- Storage: DEPTH x 64-bit register array {pc+4, instr}. Pointers are log2(DEPTH) bits and wrap naturally.
- Output path is combinational from the head entry:
  - out_valid = (count != 0) && !pc_source.
  - When out_valid=0: instr_out=NOP_INSTR and pc_next_out=0.
- pop = out_valid && id_ready.
- push = !pc_source && (count < DEPTH || pop).
  - On push: store {pc+4, imem_rdata} at wr_ptr, advance wr_ptr, pc <= pc+4.
  - When full with no pop: pc and imem_addr hold; no fetch is lost.
- count update: count + push - pop. Simultaneous push and pop on a full queue keeps count = DEPTH.
- Redirect (pc_source=1 at an edge):
  - rd_ptr = wr_ptr = 0, count = 0.
  - pc <= {pc_branch[31:2], 2'b00}; misaligned targets are truncated.
  - No push and no pop that cycle. out_valid is 0 in the redirect cycle, so decode never consumes a wrong-path entry.
- Redirect latency:
  - Edge k (redirect): pc loads the target.
  - Edge k+1: target instruction is pushed.
  - After edge k+1: out_valid=1 with the target instruction.
- Redirect has priority over full/stall/pop.
- A redirect with an empty queue behaves identically.
- PC arithmetic is 32-bit modulo; 0xFFFF_FFFC + 4 wraps to 0.
- Startup latency: first instruction is visible after the first rising edge following reset release.
- Steady state: one instruction per cycle when id_ready=1.
- Reset asserted mid-operation discards all entries; the post-release sequence restarts at RESET_PC.

Test Plan:
- Reset release, id_ready=1, imem_rdata = imem_addr ^ 32'hA5A5_0000 -> after edges 1,2,3: instr_out = A5A5_0000, A5A5_0004, A5A5_0008; pc_next_out = 4, 8, C; count stays 1.
- DEPTH=4, id_ready=0 for 8 cycles -> count saturates at 4 after edge 4; imem_addr holds 0x10. Then id_ready=1 -> drains entries for addrs 0x0, 0x4, 0x8, 0xC in order, then 0x10; none skipped or duplicated.
- Full queue, id_ready=1 for one cycle -> pop and push same edge; count remains 4; new tail entry is addr 0x10.
- Three entries queued, pc_source=1, pc_branch=0x40 -> out_valid=0 in that cycle; after the edge count=0 and imem_addr=0x40. After the next edge: out_valid=1, pc_next_out=0x44, instr from 0x40.
- pc_branch=0x43 with pc_source=1 -> imem_addr becomes 0x40.
- Assert reset between edges with count=3 -> out_valid=0, count=0, imem_addr=RESET_PC immediately, without a clock edge. After release, fetching restarts at RESET_PC.
